// File: rtl/rx_field_counter.sv
// Receive data-field word counter: captures the client length, counts data words,
// flags the last real-data and last padded words and supplies the last-word byte enables.
module rx_field_counter #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_WIDTH  = 13,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MIN_DATA   = 46,
  parameter int unsigned MAX_DATA   = 1500
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  len_valid,
  input  logic [LEN_WIDTH-1:0]  length_field,
  input  logic                  tagged_frame,
  input  logic                  start_data_cnt,
  input  logic                  abort,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  end_data_cnt,
  output logic                  end_small_cnt,
  output logic                  small_frame,
  output logic [DATA_BYTES-1:0] last_be,
  output logic                  len_error,
  output logic                  cnt_overflow,
  output logic                  busy
);

  localparam int unsigned LOG2_DB = $clog2(DATA_BYTES);
  localparam int unsigned CMP_W   = (CNT_WIDTH > LEN_WIDTH) ? CNT_WIDTH : LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_DATA);
  localparam logic [LEN_WIDTH-1:0] MIN_UNTAG = LEN_WIDTH'(MIN_DATA);
  localparam logic [LEN_WIDTH-1:0] MIN_TAG   = LEN_WIDTH'(MIN_DATA - 4);

  typedef enum logic [2:0] {IDLE, ARMED, COUNT, TYPE, DONE} state_t;

  state_t state, next_state;

  logic [LEN_WIDTH-1:0]  int_cnt, small_int_cnt;
  logic                  small_valid, type_seen;
  logic [LEN_WIDTH-1:0]  min_len, field_len, cap_int_cnt, cap_small_int;
  logic [LOG2_DB-1:0]    len_rem;
  logic [DATA_BYTES-1:0] cap_be;
  logic                  is_type, word_at_int, word_at_small;

  assign is_type       = length_field > MAX_LEN;
  assign word_at_int   = CMP_W'(word_cnt) == CMP_W'(int_cnt);
  assign word_at_small = CMP_W'(word_cnt) == CMP_W'(small_int_cnt);

  // Word indices are (bytes-1)/DATA_BYTES, i.e. ceil(bytes/DATA_BYTES)-1.
  always_comb begin
    min_len       = tagged_frame ? MIN_TAG : MIN_UNTAG;
    field_len     = (length_field > min_len) ? length_field : min_len;
    cap_int_cnt   = (field_len - LEN_WIDTH'(1)) >> LOG2_DB;
    cap_small_int = (length_field - LEN_WIDTH'(1)) >> LOG2_DB;
    len_rem       = length_field[LOG2_DB-1:0];
    cap_be        = '0;
    if (length_field == '0) begin
      cap_be = '0;
    end else if (len_rem == '0) begin
      cap_be = '1;
    end else begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        cap_be[i] = (i < 32'(len_rem));
      end
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (len_valid) next_state = is_type ? TYPE : ARMED;
        ARMED: if (start_data_cnt) next_state = end_data_cnt ? DONE : COUNT;
        COUNT: if (end_data_cnt) next_state = DONE;
        TYPE:  if (!start_data_cnt && type_seen) next_state = IDLE;
        DONE:  if (!start_data_cnt) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // end_small_cnt yields to end_data_cnt when both land on the same word.
  always_comb begin
    end_data_cnt  = 1'b0;
    end_small_cnt = 1'b0;
    busy          = (state != IDLE);
    if (state == ARMED || state == COUNT) begin
      end_data_cnt  = start_data_cnt & word_at_int;
      end_small_cnt = small_frame & small_valid & start_data_cnt
                      & word_at_small & ~word_at_int;
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      word_cnt      <= '0;
      small_frame   <= 1'b0;
      last_be       <= '0;
      len_error     <= 1'b0;
      cnt_overflow  <= 1'b0;
      int_cnt       <= '0;
      small_int_cnt <= '0;
      small_valid   <= 1'b0;
      type_seen     <= 1'b0;
    end else if (abort) begin
      word_cnt    <= '0;
      small_frame <= 1'b0;
      last_be     <= '0;
      len_error   <= 1'b0;
      type_seen   <= 1'b0;
    end else begin
      len_error <= 1'b0;
      case (state)
        IDLE: begin
          if (len_valid) begin
            word_cnt     <= '0;
            cnt_overflow <= 1'b0;
            type_seen    <= 1'b0;
            if (is_type) begin
              len_error     <= 1'b1;
              small_frame   <= 1'b0;
              last_be       <= '0;
              int_cnt       <= '0;
              small_int_cnt <= '0;
              small_valid   <= 1'b0;
            end else begin
              small_frame   <= (length_field < min_len);
              last_be       <= cap_be;
              int_cnt       <= cap_int_cnt;
              small_int_cnt <= cap_small_int;
              small_valid   <= (length_field != '0);
            end
          end
        end
        ARMED, COUNT: begin
          if (start_data_cnt && !word_at_int) begin
            if (&word_cnt) cnt_overflow <= 1'b1;
            else           word_cnt     <= word_cnt + CNT_WIDTH'(1);
          end
        end
        TYPE: begin
          if (start_data_cnt) begin
            type_seen <= 1'b1;
            if (&word_cnt) cnt_overflow <= 1'b1;
            else           word_cnt     <= word_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_field_counter.sv
// Directed bench for rx_field_counter: a default-width instance and a 3-bit counter
// instance share the stimulus; expected values are hand-computed for DATA_BYTES=8.
module tb_rx_field_counter;

  logic        rxclk = 1'b0;
  logic        reset = 1'b0;
  logic        len_valid = 1'b0;
  logic [15:0] length_field = '0;
  logic        tagged_frame = 1'b0;
  logic        start_data_cnt = 1'b0;
  logic        abort = 1'b0;

  logic [12:0] word_cnt;
  logic        end_data_cnt, end_small_cnt, small_frame, len_error, cnt_overflow, busy;
  logic [7:0]  last_be;

  logic [2:0]  n_word_cnt;
  logic        n_end_data_cnt, n_end_small_cnt, n_small_frame, n_len_error, n_cnt_overflow, n_busy;
  logic [7:0]  n_last_be;

  int checks = 0;
  int errors = 0;

  always #5 rxclk = ~rxclk;

  rx_field_counter #(.DATA_BYTES(8), .CNT_WIDTH(13), .LEN_WIDTH(16),
                     .MIN_DATA(46), .MAX_DATA(1500)) u_dut (
    .rxclk(rxclk), .reset(reset), .len_valid(len_valid), .length_field(length_field),
    .tagged_frame(tagged_frame), .start_data_cnt(start_data_cnt), .abort(abort),
    .word_cnt(word_cnt), .end_data_cnt(end_data_cnt), .end_small_cnt(end_small_cnt),
    .small_frame(small_frame), .last_be(last_be), .len_error(len_error),
    .cnt_overflow(cnt_overflow), .busy(busy)
  );

  rx_field_counter #(.DATA_BYTES(8), .CNT_WIDTH(3), .LEN_WIDTH(16),
                     .MIN_DATA(46), .MAX_DATA(1500)) u_narrow (
    .rxclk(rxclk), .reset(reset), .len_valid(len_valid), .length_field(length_field),
    .tagged_frame(tagged_frame), .start_data_cnt(start_data_cnt), .abort(abort),
    .word_cnt(n_word_cnt), .end_data_cnt(n_end_data_cnt), .end_small_cnt(n_end_small_cnt),
    .small_frame(n_small_frame), .last_be(n_last_be), .len_error(n_len_error),
    .cnt_overflow(n_cnt_overflow), .busy(n_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic setup(input logic [15:0] len, input logic tag);
    len_valid    = 1'b1;
    length_field = len;
    tagged_frame = tag;
    tick();
    len_valid    = 1'b0;
    tagged_frame = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Drives n data words (optionally with a one-cycle gap after each), then drops start.
  task automatic run(input int n, input bit gap, input int last,
                     output int ends, output int end_at, output int smalls,
                     output int small_at, output logic [7:0] sbe, output int bad_idx);
    ends = 0; end_at = -1; smalls = 0; small_at = -1; sbe = '0; bad_idx = 0;
    for (int w = 0; w < n; w++) begin
      start_data_cnt = 1'b1;
      #1;
      if (32'(word_cnt) != ((w <= last) ? w : last)) bad_idx++;
      if (end_data_cnt)  begin ends++;   end_at = 32'(word_cnt); end
      if (end_small_cnt) begin smalls++; small_at = 32'(word_cnt); sbe = last_be; end
      tick();
      if (gap) begin
        start_data_cnt = 1'b0;
        #1;
        if (end_data_cnt)  ends++;
        if (end_small_cnt) smalls++;
        tick();
      end
    end
    start_data_cnt = 1'b0;
    tick();
  endtask

  int ends, end_at, smalls, small_at, bad_idx;
  logic [7:0] sbe;

  initial begin
    tick();
    tick();
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_small", 32'(small_frame), 0);
    check("rst_last_be", 32'(last_be), 0);
    check("rst_ovf", 32'(cnt_overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", {29'd0, len_error, end_data_cnt, end_small_cnt}, 0);
    reset = 1'b1;
    tick();

    // len 100 untagged, 15 words: 13 real plus two extra in DONE
    setup(16'd100, 1'b0);
    check("l100_small", 32'(small_frame), 0);
    check("l100_be", 32'(last_be), 32'h0F);
    check("l100_busy", 32'(busy), 1);
    run(15, 1'b0, 12, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("l100_ends", ends, 1);
    check("l100_end_at", end_at, 12);
    check("l100_smalls", smalls, 0);
    check("l100_idx", bad_idx, 0);
    check("l100_idle", 32'(busy), 0);

    setup(16'd10, 1'b0);
    check("l10_small", 32'(small_frame), 1);
    check("l10_be", 32'(last_be), 32'h03);
    run(6, 1'b0, 5, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("l10_small_at", small_at, 1);
    check("l10_sbe", 32'(sbe), 32'h03);
    check("l10_end_at", end_at, 5);
    check("l10_counts", (ends << 4) | smalls, 32'h11);

    setup(16'd20, 1'b1);
    check("t20_small", 32'(small_frame), 1);
    run(6, 1'b0, 5, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("t20_small_at", small_at, 2);
    check("t20_sbe", 32'(sbe), 32'h0F);
    check("t20_end_at", end_at, 5);
    check("t20_counts", (ends << 4) | smalls, 32'h11);

    // small frame whose last real word is also the last padded word
    setup(16'd41, 1'b0);
    check("l41_small", 32'(small_frame), 1);
    check("l41_be", 32'(last_be), 32'h01);
    run(6, 1'b0, 5, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("l41_end_at", end_at, 5);
    check("l41_smalls", smalls, 0);

    setup(16'd0, 1'b0);
    check("l0_small", 32'(small_frame), 1);
    check("l0_be", 32'(last_be), 0);
    run(6, 1'b0, 5, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("l0_end_at", end_at, 5);
    check("l0_smalls", smalls, 0);

    setup(16'd64, 1'b0);
    check("l64_be", 32'(last_be), 32'hFF);
    run(8, 1'b1, 7, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("l64_ends", ends, 1);
    check("l64_end_at", end_at, 7);
    check("l64_idx", bad_idx, 0);

    // abort at word 3 of a gapped len-64 frame
    setup(16'd64, 1'b0);
    for (int w = 0; w < 3; w++) begin
      start_data_cnt = 1'b1; tick();
      start_data_cnt = 1'b0; tick();
    end
    start_data_cnt = 1'b1;
    abort = 1'b1;
    #1;
    check("abort_word", 32'(word_cnt), 3);
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_clear", {word_cnt, small_frame, last_be}, 0);
    ends = 0;
    for (int w = 0; w < 4; w++) begin
      #1;
      if (end_data_cnt || end_small_cnt) ends++;
      tick();
    end
    start_data_cnt = 1'b0;
    check("abort_no_end", ends, 0);

    abort = 1'b1;
    setup(16'd100, 1'b0);
    abort = 1'b0;
    check("abort_prio", 32'(busy), 0);

    setup(16'd1500, 1'b0);
    check("l1500_err", 32'(len_error), 0);
    check("l1500_busy", 32'(busy), 1);
    check("l1500_be", 32'(last_be), 32'h0F);
    pulse_abort();
    setup(16'd1501, 1'b0);
    check("l1501_err", 32'(len_error), 1);
    pulse_abort();

    setup(16'h0800, 1'b0);
    check("type_err", 32'(len_error), 1);
    check("type_be", {small_frame, last_be}, 0);
    tick();
    check("type_err_pulse", 32'(len_error), 0);
    check("type_wait", 32'(busy), 1);
    run(10, 1'b0, 1000, ends, end_at, smalls, small_at, sbe, bad_idx);
    check("type_no_end", (ends << 4) | smalls, 0);
    check("type_idx", bad_idx, 0);
    check("type_idle", 32'(busy), 0);
    check("sat_word", 32'(n_word_cnt), 7);
    check("sat_ovf", 32'(n_cnt_overflow), 1);
    check("wide_no_ovf", 32'(cnt_overflow), 0);

    setup(16'd100, 1'b0);
    check("ovf_cleared", 32'(n_cnt_overflow), 0);
    start_data_cnt = 1'b1;
    for (int w = 0; w < 10; w++) tick();
    check("sat2_ovf", 32'(n_cnt_overflow), 1);
    check("sat2_word", 32'(n_word_cnt), 7);
    check("mid_word", 32'(word_cnt), 10);
    reset = 1'b0;
    tick();
    check("mrst_wide", {word_cnt, small_frame, last_be, cnt_overflow, busy}, 0);
    check("mrst_pulses", {29'd0, len_error, end_data_cnt, end_small_cnt}, 0);
    check("mrst_narrow", {n_word_cnt, n_cnt_overflow, n_busy}, 0);
    reset = 1'b1;
    start_data_cnt = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
